// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: encodes symbolic instruction requests into 16-bit ISA words and writes them sequentially into IM
// Ports: clk, rst (async, active-high); start/base_addr begin a load; abort returns to IDLE;
//   req_valid/req_ready/req_op/req_rd/req_ra/req_rb/req_imm request stream; im_wen/im_addr/im_wdata IM write port;
//   busy/done/overflow status; err_cnt rejected-request count; checksum XOR of written words.
// Optional: LOADER_CHECKSUM_EN enables the checksum register (otherwise checksum is tied to zero).
module inst_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              abort,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [3:0]        req_rd,
  input  logic [3:0]        req_ra,
  input  logic [3:0]        req_rb,
  input  logic [9:0]        req_imm,
  output logic              im_wen,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [15:0]       checksum
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] wr_ptr;
  logic [15:0] word;
  logic legal, xfer, launch, halt;
  function automatic logic fits(input logic [9:0] v, input int n);
    logic [9:0] t;
    t = $signed(v) >>> (n - 1);
    return t == '0 || t == '1;
  endfunction
  assign req_ready = state == RUN;
  assign busy      = state == RUN;
  assign done      = state == DONE;
  assign xfer      = req_valid && req_ready && !abort;
  assign launch    = start && !abort && state != RUN;
  assign halt      = req_op == 5'd30;
  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (req_op) inside
      [5'd0:5'd7]: begin
        word  = {3'b000, req_op[2:0], req_rd[3], req_rb[2:0], req_ra[2:0], req_rd[2:0]};
        legal = req_rd[3] == req_ra[3] && req_ra[3] == req_rb[3];
      end
      5'd8, 5'd9, 5'd14: begin
        word  = {6'b001000, req_rd[3], req_op == 5'd8 ? 3'b000 : req_op == 5'd9 ? 3'b001 : 3'b011,
                 req_ra[2:0], req_rd[2:0]};
        legal = req_rd[3] == req_ra[3];
      end
      5'd12: begin
        word  = {10'b0010000010, req_ra[2:0], req_rd[2:0]};
        legal = req_ra[3] && !req_rd[3];
      end
      5'd13: begin
        word  = {10'b0010001010, req_ra[2:0], req_rd[2:0]};
        legal = !req_ra[3] && req_rd[3];
      end
      5'd15: begin
        word  = {6'b001001, req_rd[3], req_imm[2:0], req_ra[2:0], req_rd[2:0]};
        legal = req_rd[3] == req_ra[3] && fits(req_imm, 3);
      end
      5'd17: begin
        word  = {6'b001010, req_ra[3], req_rb[2:0], req_ra[2:0], req_imm[2:0]};
        legal = req_ra[3] == req_rb[3] && fits(req_imm, 3);
      end
      5'd16: begin
        word  = {3'b010, req_imm[8:6], req_rd[3], req_imm[5:0], req_rd[2:0]};
        legal = fits(req_imm, 9);
      end
      5'd10, 5'd11: begin
        word  = {6'b100000, req_ra[3], req_rb[2:0], req_ra[2:0], 2'b00, req_op[0]};
        legal = req_ra[3] == req_rb[3];
      end
      5'd18, 5'd19, 5'd20:
        word = {3'b100, req_op == 5'd18 ? 3'b001 : req_op == 5'd19 ? 3'b010 : 3'b100, req_imm};
      5'd21: begin
        word  = {6'b100101, req_ra[3], req_imm[5:3], req_ra[2:0], req_imm[2:0]};
        legal = fits(req_imm, 6);
      end
      5'd30: word = 16'hE000;
      default: legal = 1'b0;
    endcase
  end
  always_comb begin
    state_nx = state;
    if (abort) state_nx = IDLE;
    else if (launch) state_nx = RUN;
    else if (xfer && legal && (halt || &wr_ptr)) state_nx = DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_wen   <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
      err_cnt  <= '0;
    end else begin
      im_wen <= 1'b0;
      if (launch) begin
        wr_ptr   <= base_addr;
        overflow <= 1'b0;
        err_cnt  <= '0;
      end else if (xfer && legal) begin
        im_wen   <= 1'b1;
        im_addr  <= wr_ptr;
        im_wdata <= word;
        wr_ptr   <= wr_ptr + 1'b1;
        if (&wr_ptr && !halt) overflow <= 1'b1;
      end else if (xfer && ~&err_cnt) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] sum;
  always_ff @(posedge clk or posedge rst)
    if (rst) sum <= '0;
    else if (launch) sum <= '0;
    else if (im_wen) sum <= sum ^ im_wdata;
  assign checksum = sum;
`else
  assign checksum = 16'h0000;
`endif
endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb_inst_encoder_loader: scoreboard bench for inst_encoder_loader with directed encodings
module tb_inst_encoder_loader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, req_valid = 1'b0;
  logic [7:0] base_addr = '0;
  logic [4:0] req_op = '0;
  logic [3:0] req_rd = '0, req_ra = '0, req_rb = '0;
  logic [9:0] req_imm = '0;
  logic req_ready, im_wen, busy, done, overflow;
  logic [7:0] im_addr, err_cnt;
  logic [15:0] im_wdata, checksum;
  int checks = 0, errors = 0;
  logic [23:0] q[$];
  logic [23:0] exp_w;
  logic [7:0] ptr = '0;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [15:0] SUM1 = 16'hEC8B;
`else
  localparam logic [15:0] SUM1 = 16'h0000;
`endif
  inst_encoder_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .abort(abort),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rd(req_rd),
    .req_ra(req_ra), .req_rb(req_rb), .req_imm(req_imm), .im_wen(im_wen), .im_addr(im_addr),
    .im_wdata(im_wdata), .busy(busy), .done(done), .overflow(overflow), .err_cnt(err_cnt),
    .checksum(checksum)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (im_wen) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h required no write", im_addr, im_wdata);
      end else begin
        exp_w = q.pop_front();
        chk("im_write", {8'h0, im_addr, im_wdata}, {8'h0, exp_w});
      end
    end
  task automatic launch(input logic [7:0] b);
    start = 1'b1;
    base_addr = b;
    @(posedge clk);
    #1 start = 1'b0;
    ptr = b;
    chk("busy_after_start", busy, 1);
  endtask
  task automatic send(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [9:0] imm, input logic ok, input logic [15:0] w);
    req_op = op; req_rd = rd; req_ra = ra; req_rb = rb; req_imm = imm;
    req_valid = 1'b1;
    chk("req_ready", req_ready, 1);
    if (ok) begin
      q.push_back({ptr, w});
      ptr++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  initial begin
    #1;
    chk("rst_im_wen", im_wen, 0);
    chk("rst_im_addr", im_addr, 0);
    chk("rst_im_wdata", im_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_checksum", checksum, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    launch(8'h10);
    send(5'd3, 4'd3, 4'd1, 4'd2, 10'd0, 1, 16'h0C8B);
    send(5'd30, 4'd0, 4'd0, 4'd0, 10'd0, 1, 16'hE000);
    chk("halt_done", done, 1);
    chk("halt_ready_low", req_ready, 0);
    @(posedge clk);
    #1 chk("checksum", checksum, {16'h0, SUM1});
    launch(8'h20);
    send(5'd16, 4'd5, 4'd0, 4'd0, 10'h3FF, 1, 16'h5DFD);
    send(5'd3, 4'd9, 4'd1, 4'd2, 10'd0, 0, 16'h0);
    chk("err_bank", err_cnt, 1);
    send(5'd8, 4'd2, 4'd4, 4'd0, 10'd0, 1, 16'h2022);
    send(5'd12, 4'd1, 4'd12, 4'd0, 10'd0, 1, 16'h20A1);
    send(5'd12, 4'd9, 4'd12, 4'd0, 10'd0, 0, 16'h0);
    send(5'd15, 4'd10, 4'd11, 4'd0, 10'd3, 1, 16'h26DA);
    send(5'd15, 4'd10, 4'd11, 4'd0, 10'd4, 0, 16'h0);
    send(5'd21, 4'd0, 4'd3, 4'd0, 10'h3E0, 1, 16'h9518);
    send(5'd18, 4'd0, 4'd0, 4'd0, 10'h200, 1, 16'h8600);
    send(5'd10, 4'd0, 4'd5, 4'd6, 10'd0, 1, 16'h81A8);
    send(5'd25, 4'd0, 4'd0, 4'd0, 10'd0, 0, 16'h0);
    send(5'd17, 4'd0, 4'd1, 4'd2, 10'h3FC, 1, 16'h288C);
    send(5'd16, 4'd1, 4'd0, 4'd0, 10'd256, 0, 16'h0);
    chk("err_cnt_total", err_cnt, 5);
    chk("busy_mid", busy, 1);
    chk("done_mid", done, 0);
    send(5'd30, 4'd0, 4'd0, 4'd0, 10'd0, 1, 16'hE000);
    chk("done_second", done, 1);
    chk("no_overflow", overflow, 0);
    launch(8'hFE);
    chk("err_cleared", err_cnt, 0);
    send(5'd3, 4'd3, 4'd1, 4'd2, 10'd0, 1, 16'h0C8B);
    send(5'd3, 4'd3, 4'd1, 4'd2, 10'd0, 1, 16'h0C8B);
    req_valid = 1'b1;
    chk("ovf_ready_low", req_ready, 0);
    chk("ovf_done", done, 1);
    chk("ovf_flag", overflow, 1);
    repeat (3) @(posedge clk);
    #1 req_valid = 1'b0;
    launch(8'h40);
    chk("ovf_cleared", overflow, 0);
    send(5'd3, 4'd3, 4'd1, 4'd2, 10'd0, 1, 16'h0C8B);
    req_valid = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    req_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_no_write", im_wen, 0);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    chk("abort_beats_start", busy, 0);
    launch(8'h50);
    send(5'd3, 4'd3, 4'd1, 4'd2, 10'd0, 1, 16'h0C8B);
    req_valid = 1'b1;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_im_wen", im_wen, 0);
    chk("arst_im_addr", im_addr, 0);
    chk("arst_im_wdata", im_wdata, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", req_ready, 0);
    chk("arst_checksum", checksum, 0);
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
